// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// ============================================================================
//  jellyvl_etherneco_synctimer_pkg
//  Shared constants for the EtherNeco sync-timer master and slave cores.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package jellyvl_etherneco_synctimer_pkg;

    localparam logic [31:0] MASTER_CORE_ID = 32'hffff1121;
    localparam logic [31:0] SLAVE_CORE_ID  = 32'hffff1122;

    localparam logic [7:0]  SYNC_CMD_TYPE  = 8'h10;

    // The synchronised time sits at the head of the payload, LSB first
    localparam int unsigned SYNC_TIME_OFFSET = 0;
    localparam int unsigned SYNC_TIME_BYTES  = 8;

    localparam int unsigned ADR_CORE_ID      = 32'h00;
    localparam int unsigned ADR_ENABLE       = 32'h10;
    localparam int unsigned ADR_PERIOD       = 32'h11;
    localparam int unsigned ADR_TIMEOUT      = 32'h12;
    localparam int unsigned ADR_TIME_SET_LO  = 32'h20;
    localparam int unsigned ADR_TIME_SET_HI  = 32'h21;
    localparam int unsigned ADR_TIME_SET     = 32'h22;
    localparam int unsigned ADR_CUR_TIME_LO  = 32'h30;
    localparam int unsigned ADR_CUR_TIME_HI  = 32'h31;
    localparam int unsigned ADR_RTT          = 32'h40;
    localparam int unsigned ADR_STAT_OK      = 32'h41;
    localparam int unsigned ADR_STAT_ERR     = 32'h42;
    localparam int unsigned ADR_STAT_TIMEOUT = 32'h43;
    localparam int unsigned ADR_STAT_OVERRUN = 32'h44;

    localparam int unsigned ADR_SLV_CORE_ID     = 32'h00;
    localparam int unsigned ADR_SLV_CONTROL     = 32'h10;
    localparam int unsigned ADR_SLV_CUR_TIME_LO = 32'h30;
    localparam int unsigned ADR_SLV_CUR_TIME_HI = 32'h31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } master_state_t;

endpackage

`default_nettype wire

// File: rtl/jellyvl_etherneco_synctimer_timer.sv
// ============================================================================
//  jellyvl_etherneco_synctimer_timer
//  Free-running time base advancing NUMERATOR/DENOMINATOR units per clock.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module jellyvl_etherneco_synctimer_timer #(
    parameter int unsigned TIMER_WIDTH = 64,
    parameter int unsigned NUMERATOR   = 10,
    parameter int unsigned DENOMINATOR = 3
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   i_set_valid,
    input  logic [TIMER_WIDTH-1:0] i_set_time,
    output logic [TIMER_WIDTH-1:0] o_current_time
);

    localparam int unsigned INT_STEP   = NUMERATOR / DENOMINATOR;
    localparam int unsigned FRAC_STEP  = NUMERATOR % DENOMINATOR;
    localparam int          FRAC_WIDTH = $clog2(2 * DENOMINATOR + 1);

    logic [FRAC_WIDTH-1:0]  r_frac;
    logic [FRAC_WIDTH-1:0]  w_frac_sum;
    logic                   w_carry;
    logic [TIMER_WIDTH-1:0] r_time;

    assign w_frac_sum = r_frac + FRAC_WIDTH'(FRAC_STEP);
    assign w_carry    = (w_frac_sum >= FRAC_WIDTH'(DENOMINATOR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time <= '0;
            r_frac <= '0;
        end else if (i_set_valid) begin
            r_time <= i_set_time;
            r_frac <= '0;
        end else begin
            r_frac <= w_carry ? (w_frac_sum - FRAC_WIDTH'(DENOMINATOR)) : w_frac_sum;
            r_time <= r_time + TIMER_WIDTH'(INT_STEP) + TIMER_WIDTH'(w_carry);
        end
    end

    assign o_current_time = r_time;

endmodule

`default_nettype wire

// File: rtl/jellyvl_etherneco_synctimer_master.sv
// ============================================================================
//  jellyvl_etherneco_synctimer_master
//  Ring master: broadcasts the reference time, measures response round trip.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module jellyvl_etherneco_synctimer_master
    import jellyvl_etherneco_synctimer_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH  = 64,
    parameter int unsigned NUMERATOR    = 10,
    parameter int unsigned DENOMINATOR  = 3,
    parameter int unsigned CYCLE_WIDTH  = 32,
    parameter int unsigned STAT_WIDTH   = 32,
    parameter logic [7:0]  CMD_TYPE     = SYNC_CMD_TYPE,
    parameter logic [7:0]  CMD_NODE     = 8'h01,
    parameter int unsigned CMD_LENGTH   = 16,
    parameter bit          INIT_ENABLE  = 1'b0,
    parameter int unsigned INIT_PERIOD  = 100000,
    parameter int unsigned INIT_TIMEOUT = 50000,
    parameter int unsigned WB_ADR_WIDTH = 16,
    parameter int unsigned WB_DAT_WIDTH = 32,
    parameter int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8
) (
    input  logic                    rst,
    input  logic                    clk,

    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_we_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,

    output logic [TIMER_WIDTH-1:0]  current_time,

    output logic                    cmd_tx_start,
    output logic [15:0]             cmd_tx_length,
    output logic [7:0]              cmd_tx_type,
    output logic [7:0]              cmd_tx_node,
    output logic                    m_cmd_first,
    output logic                    m_cmd_last,
    output logic [15:0]             m_cmd_pos,
    output logic [7:0]              m_cmd_data,
    output logic                    m_cmd_valid,
    input  logic                    m_cmd_ready,

    input  logic                    res_rx_start,
    input  logic                    res_rx_end,
    input  logic                    res_rx_error,
    input  logic [15:0]             res_rx_length,
    input  logic [7:0]              res_rx_type,
    input  logic [7:0]              res_rx_node,
    input  logic                    s_res_first,
    input  logic                    s_res_last,
    input  logic [15:0]             s_res_pos,
    input  logic [7:0]              s_res_data,
    input  logic                    s_res_valid
);

    localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE = CYCLE_WIDTH'(1);
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_MAX = '1;
    localparam logic [STAT_WIDTH-1:0]  STAT_MAX  = '1;
    localparam logic [15:0]            LAST_POS  = 16'(CMD_LENGTH - 1);

    function automatic logic [WB_DAT_WIDTH-1:0] f_wmask(
        input logic [WB_DAT_WIDTH-1:0] cur,
        input logic [WB_DAT_WIDTH-1:0] dat,
        input logic [WB_SEL_WIDTH-1:0] sel
    );
        logic [WB_DAT_WIDTH-1:0] res;
        res = cur;
        for (int i = 0; i < int'(WB_SEL_WIDTH); i++) begin
            if (sel[i]) begin
                res[i*8 +: 8] = dat[i*8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] f_stat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_WIDTH'(1);
    endfunction

    logic                     r_enable;
    logic [CYCLE_WIDTH-1:0]   r_period;
    logic [CYCLE_WIDTH-1:0]   r_timeout;
    logic [WB_DAT_WIDTH-1:0]  r_set_lo;
    logic [WB_DAT_WIDTH-1:0]  r_set_hi;
    logic [WB_DAT_WIDTH-1:0]  r_time_hi_latch;
    logic [CYCLE_WIDTH-1:0]   r_period_cnt;
    logic [CYCLE_WIDTH-1:0]   r_rtt_cnt;
    logic [CYCLE_WIDTH-1:0]   r_rtt;
    logic [STAT_WIDTH-1:0]    r_stat_ok;
    logic [STAT_WIDTH-1:0]    r_stat_err;
    logic [STAT_WIDTH-1:0]    r_stat_timeout;
    logic [STAT_WIDTH-1:0]    r_stat_overrun;
    logic [TIMER_WIDTH-1:0]   r_snap;
    logic [15:0]              r_pos;
    logic [15:0]              r_tx_length;
    logic [7:0]               r_tx_type;
    logic [7:0]               r_tx_node;
    master_state_t            r_state;
    master_state_t            w_state_next;

    logic [31:0]               w_adr;
    logic                      w_wr;
    logic                      w_rd;
    logic [WB_DAT_WIDTH-1:0]   w_rdata;
    logic [WB_DAT_WIDTH-1:0]   w_enable_wdat;
    logic [WB_DAT_WIDTH-1:0]   w_period_wdat;
    logic [WB_DAT_WIDTH-1:0]   w_timeout_wdat;
    logic [2*WB_DAT_WIDTH-1:0] w_set_full;
    logic [2*WB_DAT_WIDTH-1:0] w_time_ext;
    logic                      w_time_set;
    logic [CYCLE_WIDTH-1:0]    w_period_last;
    logic                      w_trigger;
    logic [CYCLE_WIDTH-1:0]    w_rtt_next;
    logic                      w_start;
    logic                      w_ok;
    logic                      w_err;
    logic                      w_tout;
    logic                      w_overrun;
    logic [63:0]               w_snap_ext;
    logic [15:0]               w_time_idx;
    logic                      w_in_time;

    assign w_adr          = 32'(s_wb_adr_i);
    assign w_wr           = s_wb_stb_i & s_wb_we_i;
    assign w_rd           = s_wb_stb_i & ~s_wb_we_i;
    assign w_enable_wdat  = f_wmask(WB_DAT_WIDTH'(r_enable), s_wb_dat_i, s_wb_sel_i);
    assign w_period_wdat  = f_wmask(WB_DAT_WIDTH'(r_period), s_wb_dat_i, s_wb_sel_i);
    assign w_timeout_wdat = f_wmask(WB_DAT_WIDTH'(r_timeout), s_wb_dat_i, s_wb_sel_i);
    assign w_set_full     = {r_set_hi, r_set_lo};
    assign w_time_ext     = (2*WB_DAT_WIDTH)'(current_time);
    assign w_time_set     = w_wr && (w_adr == ADR_TIME_SET);

    jellyvl_etherneco_synctimer_timer #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .NUMERATOR   (NUMERATOR),
        .DENOMINATOR (DENOMINATOR)
    ) u_timer (
        .rst            (rst),
        .clk            (clk),
        .i_set_valid    (w_time_set),
        .i_set_time     (TIMER_WIDTH'(w_set_full)),
        .o_current_time (current_time)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable        <= INIT_ENABLE;
            r_period        <= CYCLE_WIDTH'(INIT_PERIOD);
            r_timeout       <= CYCLE_WIDTH'(INIT_TIMEOUT);
            r_set_lo        <= '0;
            r_set_hi        <= '0;
            r_time_hi_latch <= '0;
            r_tx_length     <= '0;
            r_tx_type       <= '0;
            r_tx_node       <= '0;
        end else begin
            r_tx_length <= 16'(CMD_LENGTH);
            r_tx_type   <= CMD_TYPE;
            r_tx_node   <= CMD_NODE;
            if (w_wr && w_adr == ADR_ENABLE)      r_enable  <= w_enable_wdat[0];
            if (w_wr && w_adr == ADR_PERIOD)      r_period  <= CYCLE_WIDTH'(w_period_wdat);
            if (w_wr && w_adr == ADR_TIMEOUT)     r_timeout <= CYCLE_WIDTH'(w_timeout_wdat);
            if (w_wr && w_adr == ADR_TIME_SET_LO) r_set_lo  <= f_wmask(r_set_lo, s_wb_dat_i, s_wb_sel_i);
            if (w_wr && w_adr == ADR_TIME_SET_HI) r_set_hi  <= f_wmask(r_set_hi, s_wb_dat_i, s_wb_sel_i);
            // Freeze the upper word so a LO-then-HI read pair is coherent
            if (w_rd && w_adr == ADR_CUR_TIME_LO) begin
                r_time_hi_latch <= w_time_ext[2*WB_DAT_WIDTH-1:WB_DAT_WIDTH];
            end
        end
    end

    // A zero period behaves as one: trigger every cycle
    assign w_period_last = (r_period == '0) ? '0 : (r_period - CYCLE_ONE);
    assign w_trigger     = r_enable && (r_period_cnt >= w_period_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (!r_enable || w_trigger) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + CYCLE_ONE;
        end
    end

    assign w_rtt_next = (r_rtt_cnt == CYCLE_MAX) ? r_rtt_cnt : (r_rtt_cnt + CYCLE_ONE);
    assign w_overrun  = w_trigger && (r_state != ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_tout       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_cmd_ready && r_pos == LAST_POS) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (res_rx_end) begin
                    if (res_rx_type == CMD_TYPE && !res_rx_error) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state_next = ST_IDLE;
                end else if (w_rtt_next >= r_timeout) begin
                    w_tout       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RTT counts the start cycle as 1, so a response N cycles later reads N
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap    <= '0;
            r_pos     <= '0;
            r_rtt_cnt <= '0;
            r_rtt     <= '0;
        end else begin
            if (w_start) begin
                r_snap    <= current_time;
                r_pos     <= '0;
                r_rtt_cnt <= '0;
            end else begin
                if (r_state != ST_IDLE) begin
                    r_rtt_cnt <= w_rtt_next;
                end
                if (r_state == ST_SEND && m_cmd_ready) begin
                    r_pos <= r_pos + 16'd1;
                end
            end
            if (w_ok) begin
                r_rtt <= w_rtt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ok      <= '0;
            r_stat_err     <= '0;
            r_stat_timeout <= '0;
            r_stat_overrun <= '0;
        end else begin
            if (w_wr && w_adr == ADR_STAT_OK)           r_stat_ok      <= '0;
            else if (w_ok)                              r_stat_ok      <= f_stat_inc(r_stat_ok);
            if (w_wr && w_adr == ADR_STAT_ERR)          r_stat_err     <= '0;
            else if (w_err)                             r_stat_err     <= f_stat_inc(r_stat_err);
            if (w_wr && w_adr == ADR_STAT_TIMEOUT)      r_stat_timeout <= '0;
            else if (w_tout)                            r_stat_timeout <= f_stat_inc(r_stat_timeout);
            if (w_wr && w_adr == ADR_STAT_OVERRUN)      r_stat_overrun <= '0;
            else if (w_overrun)                         r_stat_overrun <= f_stat_inc(r_stat_overrun);
        end
    end

    assign w_snap_ext = 64'(r_snap);
    assign w_time_idx = r_pos - 16'(SYNC_TIME_OFFSET);
    assign w_in_time  = (w_time_idx < 16'(SYNC_TIME_BYTES));

    assign cmd_tx_start  = w_start;
    assign cmd_tx_length = r_tx_length;
    assign cmd_tx_type   = r_tx_type;
    assign cmd_tx_node   = r_tx_node;
    assign m_cmd_valid   = (r_state == ST_SEND);
    assign m_cmd_pos     = m_cmd_valid ? r_pos : 16'd0;
    assign m_cmd_first   = m_cmd_valid && (r_pos == 16'd0);
    assign m_cmd_last    = m_cmd_valid && (r_pos == LAST_POS);
    assign m_cmd_data    = (m_cmd_valid && w_in_time) ? w_snap_ext[{w_time_idx[2:0], 3'b000} +: 8] : 8'h00;

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            ADR_CORE_ID:      w_rdata = WB_DAT_WIDTH'(MASTER_CORE_ID);
            ADR_ENABLE:       w_rdata = WB_DAT_WIDTH'(r_enable);
            ADR_PERIOD:       w_rdata = WB_DAT_WIDTH'(r_period);
            ADR_TIMEOUT:      w_rdata = WB_DAT_WIDTH'(r_timeout);
            ADR_TIME_SET_LO:  w_rdata = r_set_lo;
            ADR_TIME_SET_HI:  w_rdata = r_set_hi;
            ADR_CUR_TIME_LO:  w_rdata = w_time_ext[WB_DAT_WIDTH-1:0];
            ADR_CUR_TIME_HI:  w_rdata = r_time_hi_latch;
            ADR_RTT:          w_rdata = WB_DAT_WIDTH'(r_rtt);
            ADR_STAT_OK:      w_rdata = WB_DAT_WIDTH'(r_stat_ok);
            ADR_STAT_ERR:     w_rdata = WB_DAT_WIDTH'(r_stat_err);
            ADR_STAT_TIMEOUT: w_rdata = WB_DAT_WIDTH'(r_stat_timeout);
            ADR_STAT_OVERRUN: w_rdata = WB_DAT_WIDTH'(r_stat_overrun);
            default:          w_rdata = '0;
        endcase
    end

    assign s_wb_dat_o = s_wb_stb_i ? w_rdata : '0;
    assign s_wb_ack_o = s_wb_stb_i;

    logic w_unused;
    assign w_unused = &{1'b0, res_rx_start, res_rx_length, res_rx_node, s_res_first,
                        s_res_last, s_res_pos, s_res_data, s_res_valid,
                        w_enable_wdat[WB_DAT_WIDTH-1:1]};

endmodule

`default_nettype wire

// File: tb/tb_jellyvl_etherneco_synctimer_master.sv
// ============================================================================
//  tb_jellyvl_etherneco_synctimer_master
//  Directed self-checking bench for the sync-timer ring master.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jellyvl_etherneco_synctimer_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_wb_adr_i = '0;
    logic [31:0] s_wb_dat_o;
    logic [31:0] s_wb_dat_i = '0;
    logic [3:0]  s_wb_sel_i = '0;
    logic        s_wb_we_i  = 1'b0;
    logic        s_wb_stb_i = 1'b0;
    logic        s_wb_ack_o;
    logic [63:0] current_time;
    logic        cmd_tx_start;
    logic [15:0] cmd_tx_length;
    logic [7:0]  cmd_tx_type;
    logic [7:0]  cmd_tx_node;
    logic        m_cmd_first;
    logic        m_cmd_last;
    logic [15:0] m_cmd_pos;
    logic [7:0]  m_cmd_data;
    logic        m_cmd_valid;
    logic        m_cmd_ready   = 1'b0;
    logic        res_rx_start  = 1'b0;
    logic        res_rx_end    = 1'b0;
    logic        res_rx_error  = 1'b0;
    logic [15:0] res_rx_length = '0;
    logic [7:0]  res_rx_type   = '0;
    logic [7:0]  res_rx_node   = '0;
    logic        s_res_first   = 1'b0;
    logic        s_res_last    = 1'b0;
    logic [15:0] s_res_pos     = '0;
    logic [7:0]  s_res_data    = '0;
    logic        s_res_valid   = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jellyvl_etherneco_synctimer_master u_dut (
        .rst           (rst),
        .clk           (clk),
        .s_wb_adr_i    (s_wb_adr_i),
        .s_wb_dat_o    (s_wb_dat_o),
        .s_wb_dat_i    (s_wb_dat_i),
        .s_wb_sel_i    (s_wb_sel_i),
        .s_wb_we_i     (s_wb_we_i),
        .s_wb_stb_i    (s_wb_stb_i),
        .s_wb_ack_o    (s_wb_ack_o),
        .current_time  (current_time),
        .cmd_tx_start  (cmd_tx_start),
        .cmd_tx_length (cmd_tx_length),
        .cmd_tx_type   (cmd_tx_type),
        .cmd_tx_node   (cmd_tx_node),
        .m_cmd_first   (m_cmd_first),
        .m_cmd_last    (m_cmd_last),
        .m_cmd_pos     (m_cmd_pos),
        .m_cmd_data    (m_cmd_data),
        .m_cmd_valid   (m_cmd_valid),
        .m_cmd_ready   (m_cmd_ready),
        .res_rx_start  (res_rx_start),
        .res_rx_end    (res_rx_end),
        .res_rx_error  (res_rx_error),
        .res_rx_length (res_rx_length),
        .res_rx_type   (res_rx_type),
        .res_rx_node   (res_rx_node),
        .s_res_first   (s_res_first),
        .s_res_last    (s_res_last),
        .s_res_pos     (s_res_pos),
        .s_res_data    (s_res_data),
        .s_res_valid   (s_res_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        s_wb_adr_i = adr;
        s_wb_dat_i = dat;
        s_wb_sel_i = sel;
        s_wb_we_i  = 1'b1;
        s_wb_stb_i = 1'b1;
        tick();
        s_wb_stb_i = 1'b0;
        s_wb_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [15:0] adr, output logic [31:0] dat);
        s_wb_adr_i = adr;
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b1;
        #1;
        dat = s_wb_dat_o;
        tick();
        s_wb_stb_i = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit found);
        found = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (cmd_tx_start) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] t0;
        logic [63:0] snap;
        logic [7:0]  eb;
        bit          found;
        int          gap;
        int          idx;

        // Reset state
        #2;
        chk("rst_valid",  {63'd0, m_cmd_valid}, 64'd0);
        chk("rst_start",  {63'd0, cmd_tx_start}, 64'd0);
        chk("rst_length", {48'd0, cmd_tx_length}, 64'd0);
        chk("rst_time",   current_time, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("hdr", {40'd0, cmd_tx_length, cmd_tx_type, cmd_tx_node}, {40'd0, 16'd16, 8'h10, 8'h01});

        // Fractional timer 10/3
        t0 = current_time;
        repeat (3) tick();
        chk("timer_3", current_time - t0, 64'd10);
        t0 = current_time;
        repeat (300) tick();
        chk("timer_300", current_time - t0, 64'd1000);

        // Register bank defaults
        wb_read(16'h00, rd); chk("core_id", {32'd0, rd}, 64'hffff1121);
        wb_read(16'h10, rd); chk("enable0", {32'd0, rd}, 64'd0);
        wb_read(16'h11, rd); chk("period0", {32'd0, rd}, 64'd100000);
        wb_read(16'h12, rd); chk("timeout0", {32'd0, rd}, 64'd50000);
        wb_read(16'h05, rd); chk("unmapped", {32'd0, rd}, 64'd0);
        s_wb_stb_i = 1'b1;
        #1;
        chk("ack", {63'd0, s_wb_ack_o}, 64'd1);
        s_wb_stb_i = 1'b0;
        tick();

        // Byte-select write: only the low byte of 0x186A0 is replaced
        wb_write(16'h11, 32'hFFFFFF14, 4'b0001);
        wb_read(16'h11, rd); chk("period_sel", {32'd0, rd}, 64'h18614);

        // Time set
        wb_write(16'h20, 32'h1234, 4'hf);
        wb_write(16'h21, 32'h1, 4'hf);
        wb_write(16'h22, 32'h0, 4'hf);
        chk("time_set", current_time, 64'h1_00001234);
        tick();
        chk("time_set_inc", current_time, 64'h1_00001237);
        wb_read(16'h30, rd);
        wb_read(16'h31, rd); chk("cur_hi_latch", {32'd0, rd}, 64'd1);

        // Frame content and period, with a short timeout
        wb_write(16'h12, 32'd10, 4'hf);
        wb_write(16'h11, 32'd20, 4'hf);
        m_cmd_ready = 1'b1;
        wb_write(16'h10, 32'd1, 4'hf);
        wait_start(100, found);
        chk("start1", {63'd0, found}, 64'd1);
        snap = current_time;
        for (int i = 0; i < 16; i++) begin
            tick();
            eb = (i < 8) ? snap[i*8 +: 8] : 8'h00;
            chk($sformatf("byte%0d", i),
                {37'd0, m_cmd_valid, m_cmd_first, m_cmd_last, m_cmd_pos, m_cmd_data},
                {37'd0, 1'b1, (i == 0), (i == 15), 16'(i), eb});
        end
        gap = 0;
        for (int k = 17; k < 60; k++) begin
            tick();
            if (cmd_tx_start) begin
                gap = k;
                break;
            end
        end
        chk("period20", 64'(gap), 64'd20);
        wb_write(16'h10, 32'd0, 4'hf);
        repeat (40) tick();
        chk("idle_after_timeout", {63'd0, m_cmd_valid}, 64'd0);
        wb_read(16'h43, rd); chk("stat_timeout", {32'd0, rd}, 64'd2);
        wb_read(16'h44, rd); chk("stat_overrun0", {32'd0, rd}, 64'd0);
        wb_write(16'h43, 32'h5a, 4'hf);
        wb_read(16'h43, rd); chk("stat_timeout_clr", {32'd0, rd}, 64'd0);

        // Back-pressure then a good response 37 cycles after start
        wb_write(16'h12, 32'd50000, 4'hf);
        wb_write(16'h11, 32'd200, 4'hf);
        wb_write(16'h10, 32'd1, 4'hf);
        wait_start(300, found);
        chk("start_bp", {63'd0, found}, 64'd1);
        snap = current_time;
        idx  = 0;
        for (int k = 1; k <= 37; k++) begin
            tick();
            m_cmd_ready = !(k >= 4 && k <= 8);
            if (m_cmd_valid && idx < 16) begin
                eb = (idx < 8) ? snap[idx*8 +: 8] : 8'h00;
                chk($sformatf("bp_c%0d", k), {40'd0, m_cmd_pos, m_cmd_data}, {40'd0, 16'(idx), eb});
                if (m_cmd_ready) idx++;
            end
            if (k == 37) begin
                res_rx_end  = 1'b1;
                res_rx_type = 8'h10;
            end
        end
        tick();
        res_rx_end = 1'b0;
        chk("bp_count", 64'(idx), 64'd16);
        wb_read(16'h40, rd); chk("rtt", {32'd0, rd}, 64'd37);
        wb_read(16'h41, rd); chk("stat_ok", {32'd0, rd}, 64'd1);

        // Type-mismatch response counts as an error
        m_cmd_ready = 1'b1;
        wait_start(300, found);
        chk("start_err", {63'd0, found}, 64'd1);
        repeat (20) tick();
        res_rx_end  = 1'b1;
        res_rx_type = 8'h11;
        tick();
        res_rx_end  = 1'b0;
        res_rx_type = 8'h00;
        wb_write(16'h10, 32'd0, 4'hf);
        wb_read(16'h42, rd); chk("stat_err", {32'd0, rd}, 64'd1);
        wb_read(16'h41, rd); chk("stat_ok_hold", {32'd0, rd}, 64'd1);
        wb_read(16'h44, rd); chk("stat_overrun_pre", {32'd0, rd}, 64'd0);

        // Overrun: PERIOD=5 with the sink stalled
        wb_write(16'h11, 32'd5, 4'hf);
        m_cmd_ready = 1'b0;
        wb_write(16'h10, 32'd1, 4'hf);
        wait_start(20, found);
        chk("start_ovr", {63'd0, found}, 64'd1);
        repeat (21) tick();
        wb_write(16'h10, 32'd0, 4'hf);
        wb_read(16'h44, rd); chk("stat_overrun", {32'd0, rd}, 64'd4);
        chk("stalled_send", {47'd0, m_cmd_valid, m_cmd_pos}, {47'd0, 1'b1, 16'd0});

        // Asynchronous reset mid-SEND
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, m_cmd_valid}, 64'd0);
        chk("arst_time", current_time, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        wb_read(16'h10, rd); chk("arst_enable", {32'd0, rd}, 64'd0);
        wb_read(16'h11, rd); chk("arst_period", {32'd0, rd}, 64'd100000);
        wb_read(16'h12, rd); chk("arst_timeout", {32'd0, rd}, 64'd50000);
        wb_read(16'h44, rd); chk("arst_overrun", {32'd0, rd}, 64'd0);
        wb_read(16'h40, rd); chk("arst_rtt", {32'd0, rd}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jellyvl_etherneco_synctimer_master.md
Name: jellyvl_etherneco_synctimer_master

Overview:
- Ring-master end of the EtherNeco sync-timer protocol.
- Keeps the reference time and broadcasts it periodically as a time-sync command frame on the ring's command path.
- Receives the returning response frame, measures round-trip cycles, and keeps ok/error/timeout/overrun statistics.
- Wishbone-slave register bank for control and monitoring; sits beside the ring master's packet mux.

Parameters:
- TIMER_WIDTH, 64, timer bit width.
- NUMERATOR, 10, clock period numerator (time units per clock = NUMERATOR/DENOMINATOR).
- DENOMINATOR, 3, clock period denominator.
- CYCLE_WIDTH, 32, width of period, timeout and RTT counters.
- STAT_WIDTH, 32, statistics counter width.
- CMD_TYPE, 8'h10, packet type of sync command.
- CMD_NODE, 8'h01, first node id placed in the header.
- CMD_LENGTH, 16, payload bytes; minimum 8.
- INIT_ENABLE, 0, reset value of the enable register.
- INIT_PERIOD, 100000, reset value of the period register, in cycles.
- INIT_TIMEOUT, 50000, reset value of the response timeout register, in cycles.
- WB_ADR_WIDTH, 16, Wishbone address width.
- WB_DAT_WIDTH, 32, Wishbone data width.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, Wishbone byte-select width.

Ports:
- rst  in  1  reset; asynchronous, active-high.
- clk  in  1  the single clock.
- s_wb_adr_i  in  WB_ADR_WIDTH  Wishbone address.
- s_wb_dat_o  out  WB_DAT_WIDTH  Wishbone read data.
- s_wb_dat_i  in  WB_DAT_WIDTH  Wishbone write data.
- s_wb_sel_i  in  WB_SEL_WIDTH  Wishbone byte selects.
- s_wb_we_i  in  1  Wishbone write enable.
- s_wb_stb_i  in  1  Wishbone strobe.
- s_wb_ack_o  out  1  Wishbone acknowledge.
- current_time  out  TIMER_WIDTH  master reference time.
- cmd_tx_start  out  1  one-cycle frame-start pulse.
- cmd_tx_length  out  16  payload length, always CMD_LENGTH.
- cmd_tx_type  out  8  packet type, always CMD_TYPE.
- cmd_tx_node  out  8  first node id, always CMD_NODE.
- m_cmd_first  out  1  first payload byte flag.
- m_cmd_last  out  1  last payload byte flag.
- m_cmd_pos  out  16  payload byte position.
- m_cmd_data  out  8  payload byte.
- m_cmd_valid  out  1  payload byte valid.
- m_cmd_ready  in  1  downstream accepts the current byte.
- res_rx_start  in  1  response frame start.
- res_rx_end  in  1  response frame end.
- res_rx_error  in  1  response frame error.
- res_rx_length  in  16  response length.
- res_rx_type  in  8  response type.
- res_rx_node  in  8  response node.
- s_res_first, s_res_last  in  1 each  response byte flags; accepted and ignored.
- s_res_pos  in  16  response byte position; accepted and ignored.
- s_res_data  in  8  response byte; accepted and ignored.
- s_res_valid  in  1  response byte valid; accepted and ignored.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst. All flops clear immediately on rst; all outputs are 0 in reset.
- Timer:
  - Each clock, current_time += NUMERATOR/DENOMINATOR (integer part).
  - Fraction accumulator += NUMERATOR%DENOMINATOR; when it reaches ≥DENOMINATOR, subtract DENOMINATOR and add 1 more to the time.
  - Time wraps modulo 2^TIMER_WIDTH.
  - Writing TIME_SET loads current_time from the staged LO/HI words on the next cycle and clears the fraction accumulator.
- Period counter: free-running when enable=1, counting 0..PERIOD-1. The terminal count produces a trigger. enable=0 holds the counter at 0.
- FSM states:
  - IDLE: on trigger, latch snap = current_time and pulse cmd_tx_start. RTT counter is cleared that cycle. Go to SEND.
  - SEND:
    - Drive bytes pos 0..CMD_LENGTH-1 with valid=1. pos advances only when valid & ready; data/pos stay stable while ready=0.
    - Bytes 0..7 are snap, LSB first; bytes 8 and up are 0.
    - first = (pos==0); last = (pos==CMD_LENGTH-1). Accepting the last byte goes to WAIT.
  - WAIT:
    - res_rx_end with res_rx_type==CMD_TYPE and !res_rx_error: rtt_reg = RTT count, stat_ok++, go to IDLE.
    - res_rx_end with error, or with a type mismatch: stat_err++, go to IDLE.
    - RTT count reaches TIMEOUT: stat_timeout++, go to IDLE.
    - If end and timeout coincide, the end wins.
- RTT counter increments every cycle from cmd_tx_start until it leaves WAIT, and saturates at its maximum.
- Trigger outside IDLE: the frame is skipped and stat_overrun++. A trigger in the same cycle WAIT→IDLE is also an overrun.
- Statistics counters saturate at all-ones. Writing any value to a statistics register clears it.
- Clearing enable mid-frame: the current frame completes; no new triggers occur.
- Wishbone:
  - s_wb_ack_o = s_wb_stb_i, combinational.
  - Writes honour byte selects. Read data is combinational, 0 at unmapped addresses.
- Register map:
  - 0x00 CORE_ID = 0xffff1121, RO.
  - 0x10 ENABLE.
  - 0x11 PERIOD.
  - 0x12 TIMEOUT.
  - 0x20 TIME_SET_LO.
  - 0x21 TIME_SET_HI.
  - 0x22 TIME_SET: any write triggers the load.
  - 0x30 CUR_TIME_LO: a read latches the high word.
  - 0x31 CUR_TIME_HI: returns the latched high word.
  - 0x40 RTT, RO.
  - 0x41 STAT_OK.
  - 0x42 STAT_ERR.
  - 0x43 STAT_TIMEOUT.
  - 0x44 STAT_OVERRUN.
- PERIOD=0 is treated as 1, i.e. a trigger every cycle.

Decomposition:
- Shared package jellyvl_etherneco_synctimer_pkg: register address constants for master and slave, CORE_ID values, sync CMD_TYPE, payload byte offsets.
- One sub-module, jellyvl_etherneco_synctimer_timer: fractional NUMERATOR/DENOMINATOR timer with a load port. The slave core reuses it.

Test Plan:
- Timer, NUMERATOR=10, DENOMINATOR=3, enable=0: after 3 cycles current_time +10; after 300 cycles +1000.
- Frame content, PERIOD=20, ENABLE=1, ready=1:
  - cmd_tx_start pulses once per 20 cycles.
  - 16 bytes follow: bytes 0-7 equal the latched time LSB-first, bytes 8-15 = 0, first at pos 0, last at pos 15.
- Back-pressure: ready low for 5 cycles mid-frame → pos and data held stable; no byte lost or duplicated.
- Good response: res_rx_end with type 0x10 and no error, 37 cycles after start → RTT reads 37, STAT_OK=1.
- Timeout and overrun:
  - TIMEOUT=10, no response → STAT_TIMEOUT=1, FSM back in IDLE.
  - PERIOD=5 with ready=0 → STAT_OVERRUN increments.
- Time set and async reset:
  - Write LO=0x1234, HI=0x1, then TIME_SET → time = 0x1_00001234 the next cycle.
  - Assert rst mid-SEND → m_cmd_valid drops immediately and all registers return to INIT values.
